// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad constants, scan FSM state type and key-set helpers
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int KEY_W    = 4;
  localparam int ROW_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_EVAL
  } scan_state_t;

  // Index of the lowest closed key; 0 when the set is empty.
  function automatic logic [KEY_W-1:0] lowest_key(input logic [NUM_KEYS-1:0] keys);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) idx = KEY_W'(i);
    end
    return idx;
  endfunction

  // True when two or more keys are set (clearing the lowest bit leaves something).
  function automatic logic multi_key(input logic [NUM_KEYS-1:0] keys);
    return (keys & (keys - {{(NUM_KEYS-1){1'b0}}, 1'b1})) != '0;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// rtl/keypad_if.sv - key event handshake bundle between scanner and consumer
interface keypad_if;

  logic                         EVT_VALID;
  logic                         EVT_READY;
  logic [keypad_pkg::KEY_W-1:0] EVT_CODE;
  logic                         EVT_PRESS;

  modport master (
    output EVT_VALID,
    output EVT_CODE,
    output EVT_PRESS,
    input  EVT_READY
  );

  modport slave (
    input  EVT_VALID,
    input  EVT_CODE,
    input  EVT_PRESS,
    output EVT_READY
  );

endinterface

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - per-scan snapshot capture, stability counting and debounced key state
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                abort,
  input  logic                sample_en,
  input  logic [ROW_W-1:0]    row,
  input  logic [NUM_COLS-1:0] col,
  input  logic                eval_en,
  output logic                commit,
  output logic [NUM_KEYS-1:0] new_state,
  output logic [NUM_KEYS-1:0] old_state
);

  localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_SCANS);

  logic [NUM_KEYS-1:0] snapshot;
  logic [NUM_KEYS-1:0] prev_snapshot;
  logic [NUM_KEYS-1:0] debounced;
  logic [3:0]          stable_cnt;
  logic [3:0]          cnt_next;
  logic                same;
  logic                reached;

  // Stability count for the scan just finished; a fresh run of length DEB_MAX counts as reaching it.
  always_comb begin
    same = (snapshot == prev_snapshot);
    if (!same) begin
      cnt_next = 4'd1;
    end else if (stable_cnt == DEB_MAX) begin
      cnt_next = DEB_MAX;
    end else begin
      cnt_next = stable_cnt + 4'd1;
    end
    reached   = (cnt_next == DEB_MAX) && (!same || (stable_cnt != DEB_MAX));
    commit    = eval_en && reached && (snapshot != debounced);
    new_state = snapshot;
    old_state = debounced;
  end

  // Snapshot/history/debounced registers; an aborted scan discards its partial snapshot and run length.
  always_ff @(posedge clk) begin
    if (rst) begin
      snapshot      <= '0;
      prev_snapshot <= '0;
      debounced     <= '0;
      stable_cnt    <= '0;
    end else if (abort) begin
      snapshot   <= '0;
      stable_cnt <= '0;
    end else begin
      if (sample_en) begin
        snapshot[int'(row) * NUM_COLS +: NUM_COLS] <= col;
      end
      if (eval_en) begin
        prev_snapshot <= snapshot;
        stable_cnt    <= cnt_next;
        if (commit) debounced <= snapshot;
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 keypad row scanner with debounce and event register (option: KEYPAD_RELEASE_EVT_EN)
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 15,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SCAN_EN,
  input  logic [NUM_COLS-1:0] COL,
  output logic [NUM_ROWS-1:0] ROW_DRV,
  keypad_if.master            evt,
  output logic                ERROR,
  output logic                OVERFLOW,
  input  logic                ERR_CLR
);

  scan_state_t         state;
  scan_state_t         state_next;
  logic [ROW_W-1:0]    row;
  logic [ROW_W-1:0]    row_next;
  logic [7:0]          settle_cnt;
  logic [7:0]          settle_next;
  logic [NUM_COLS-1:0] col_s1;
  logic [NUM_COLS-1:0] col_s2;
  logic                abort;
  logic                sample_en;
  logic                eval_en;
  logic                commit;
  logic [NUM_KEYS-1:0] new_state;
  logic [NUM_KEYS-1:0] old_state;
  logic [NUM_KEYS-1:0] rose;
  logic                ev_load;
  logic [KEY_W-1:0]    ev_code;
  logic                ev_drop;
  logic                err_set;
  logic                ev_lost;
  logic                xfer;
  logic                evt_valid;
  logic [KEY_W-1:0]    evt_code;
`ifdef KEYPAD_RELEASE_EVT_EN
  logic [NUM_KEYS-1:0] fell;
  logic                ev_press;
  logic                evt_press;
`endif

  // Two-flop synchronizer on the raw column sense lines.
  always_ff @(posedge CLK) begin
    if (RST) begin
      col_s1 <= '0;
      col_s2 <= '0;
    end else begin
      col_s1 <= COL;
      col_s2 <= col_s1;
    end
  end

  // Scan FSM state, row index and settle counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      row        <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= state_next;
      row        <= row_next;
      settle_cnt <= settle_next;
    end
  end

  // Next-state and row drive; dropping SCAN_EN mid-scan overrides everything and returns to IDLE.
  always_comb begin
    state_next  = state;
    row_next    = row;
    settle_next = settle_cnt;
    ROW_DRV     = '0;
    sample_en   = 1'b0;
    eval_en     = 1'b0;
    abort       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (SCAN_EN) begin
          state_next  = ST_DRIVE;
          row_next    = '0;
          settle_next = '0;
        end
      end
      ST_DRIVE: begin
        ROW_DRV = NUM_ROWS'(1) << row;
        if (settle_cnt == 8'(SETTLE_CYCLES - 1)) begin
          state_next  = ST_SAMPLE;
          settle_next = '0;
        end else begin
          settle_next = settle_cnt + 8'd1;
        end
      end
      ST_SAMPLE: begin
        ROW_DRV   = NUM_ROWS'(1) << row;
        sample_en = 1'b1;
        if (row == ROW_W'(NUM_ROWS - 1)) begin
          state_next = ST_EVAL;
        end else begin
          state_next = ST_DRIVE;
          row_next   = row + ROW_W'(1);
        end
      end
      ST_EVAL: begin
        eval_en     = 1'b1;
        state_next  = ST_DRIVE;
        row_next    = '0;
        settle_next = '0;
      end
      default: state_next = ST_IDLE;
    endcase
    if (!SCAN_EN && (state != ST_IDLE)) begin
      abort       = 1'b1;
      state_next  = ST_IDLE;
      row_next    = '0;
      settle_next = '0;
      sample_en   = 1'b0;
      eval_en     = 1'b0;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk       (CLK),
    .rst       (RST),
    .abort     (abort),
    .sample_en (sample_en),
    .row       (row),
    .col       (col_s2),
    .eval_en   (eval_en),
    .commit    (commit),
    .new_state (new_state),
    .old_state (old_state)
  );

  // Turn a debounced commit into at most one event; a multi-key state is an error, not an event.
  always_comb begin
    rose    = new_state & ~old_state;
    ev_load = 1'b0;
    ev_code = '0;
    ev_drop = 1'b0;
    err_set = 1'b0;
`ifdef KEYPAD_RELEASE_EVT_EN
    fell     = old_state & ~new_state;
    ev_press = 1'b1;
`endif
    if (commit) begin
      if (multi_key(new_state)) begin
        err_set = 1'b1;
      end else if (rose != '0) begin
        ev_load = 1'b1;
        ev_code = lowest_key(rose);
`ifdef KEYPAD_RELEASE_EVT_EN
        ev_drop = (fell != '0);
      end else if (fell != '0) begin
        ev_load  = 1'b1;
        ev_code  = lowest_key(fell);
        ev_press = 1'b0;
        ev_drop  = multi_key(fell);
`endif
      end
    end
  end

  assign xfer    = evt_valid && evt.EVT_READY;
  assign ev_lost = ev_load && evt_valid && !evt.EVT_READY;

  // Event holding register; a held event is never overwritten until it is transferred.
  always_ff @(posedge CLK) begin
    if (RST) begin
      evt_valid <= 1'b0;
      evt_code  <= '0;
`ifdef KEYPAD_RELEASE_EVT_EN
      evt_press <= 1'b0;
`endif
    end else if (ev_load && (!evt_valid || xfer)) begin
      evt_valid <= 1'b1;
      evt_code  <= ev_code;
`ifdef KEYPAD_RELEASE_EVT_EN
      evt_press <= ev_press;
`endif
    end else if (xfer) begin
      evt_valid <= 1'b0;
    end
  end

  // Sticky error/overflow flags; a set in the same cycle as ERR_CLR takes priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERROR    <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      if (err_set) ERROR <= 1'b1;
      else if (ERR_CLR) ERROR <= 1'b0;
      if (ev_lost || ev_drop) OVERFLOW <= 1'b1;
      else if (ERR_CLR) OVERFLOW <= 1'b0;
    end
  end

  assign evt.EVT_VALID = evt_valid;
  assign evt.EVT_CODE  = evt_code;
`ifdef KEYPAD_RELEASE_EVT_EN
  assign evt.EVT_PRESS = evt_press;
`else
  assign evt.EVT_PRESS = 1'b1;
`endif

endmodule
